// File: rtl/memory_matrix_pkg.sv
// -----------------------------------------------------------------------------
// memory_matrix_pkg
// Shared constants and types for the Memory Matrix play datapath.
//   BOARD_W / IDX_W   : board size and tile index width (also used by the
//                       guess-check, guess-counter and display stages)
//   MAX_TILES         : upper clamp on the requested lit-tile count
//   LFSR_W / SEED     : LFSR width and reset value (non-zero)
//   LFSR_TAP_MASK     : feedback taps for x^16+x^14+x^13+x^11+1 in the
//                       right-shifting Fibonacci form (bits 0,2,3,5)
//   bg_state_e        : board generator FSM encoding
// Helpers: lfsr_next() (one LFSR step), clamp_target() (tile count clamp).
// -----------------------------------------------------------------------------
package memory_matrix_pkg;

  localparam int          BOARD_W       = 8;
  localparam int          IDX_W         = 3;
  localparam int          LFSR_W        = 16;
  localparam logic [3:0]  MAX_TILES     = 4'd7;
  localparam logic [15:0] SEED          = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    PLACE  = 2'd2,
    FINISH = 2'd3
  } bg_state_e;

  // One LFSR step: XOR of the tapped bits enters at the MSB while the
  // register shifts towards bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    logic fb;
    fb = ^(q & LFSR_TAP_MASK);
    return {fb, q[15:1]};
  endfunction

  // Zero requests still light one tile; anything above MAX_TILES is cut
  // back so that placement can always terminate on an 8-tile board.
  function automatic logic [3:0] clamp_target(input logic [3:0] n);
    logic [3:0] t;
    if (n == 4'd0) begin
      t = 4'd1;
    end else if (n > MAX_TILES) begin
      t = MAX_TILES;
    end else begin
      t = n;
    end
    return t;
  endfunction

endpackage

// File: rtl/board_generator_if.sv
// -----------------------------------------------------------------------------
// board_generator_if
// Request/result bundle between the player-input side and the board
// generator.
//   start        : level request, acted on at its rising edge
//   num_tiles    : requested lit-tile count, sampled on the accepted edge
//   board        : solution board, 1 = lit tile
//   busy         : generation in progress
//   done         : one-cycle pulse when the board is final
//   tiles_placed : tiles placed in the current/last generation
// Modports: master drives the request, slave (the generator) drives results.
// -----------------------------------------------------------------------------
interface board_generator_if;
  import memory_matrix_pkg::*;

  logic               start;
  logic [3:0]         num_tiles;
  logic [BOARD_W-1:0] board;
  logic               busy;
  logic               done;
  logic [3:0]         tiles_placed;

  modport master (
    output start,
    output num_tiles,
    input  board,
    input  busy,
    input  done,
    input  tiles_placed
  );

  modport slave (
    input  start,
    input  num_tiles,
    output board,
    output busy,
    output done,
    output tiles_placed
  );

endinterface

// File: rtl/board_generator_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1). It advances on
// every clock outside reset, so the value seen at any moment depends on when
// the player pressed the key.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low; loads INIT
//   q     : current LFSR value
// -----------------------------------------------------------------------------
module lfsr16
  import memory_matrix_pkg::*;
#(
  parameter logic [15:0] INIT = SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_r;

  // LFSR register: reload on reset, otherwise step every cycle. The all-zero
  // lock-up state is unreachable from a non-zero seed; if an upset ever puts
  // the register there, reload the seed rather than stall placement forever.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r <= INIT;
    end else if (q_r == 16'h0000) begin
      q_r <= INIT;
    end else begin
      q_r <= lfsr_next(q_r);
    end
  end

  assign q = q_r;

endmodule

// File: rtl/board_generator.sv
// -----------------------------------------------------------------------------
// board_generator
// Builds a random BOARD_W-tile solution board with exactly the clamped
// number of lit tiles. A rising edge on start (while idle) latches the
// target, clears the working board, then lights one tile per cycle at the
// index given by the low LFSR bits, retrying on collisions. When the target
// is reached the working board is copied to the visible board and done
// pulses for one cycle.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low; aborts any generation, board reads 0
//   bus   : board_generator_if.slave (start, num_tiles in; board, busy,
//           done, tiles_placed out)
// -----------------------------------------------------------------------------
module board_generator
  import memory_matrix_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  board_generator_if.slave   bus
);

  bg_state_e          state_r;
  bg_state_e          state_next_s;

  logic [15:0]        lfsr_s;
  logic [IDX_W-1:0]   idx_s;
  logic               unused_lfsr_hi_s;

  logic               start_q_r;
  logic               accept_s;
  logic [3:0]         target_r;
  logic [BOARD_W-1:0] work_r;
  logic [BOARD_W-1:0] board_r;
  logic [3:0]         tiles_r;
  logic [3:0]         tiles_inc_s;
  logic               slot_free_s;
  logic               busy_r;
  logic               done_r;

  logic               clear_s;
  logic               place_s;
  logic               load_board_s;
  logic               busy_next_s;
  logic               done_next_s;

  lfsr16 #(
    .INIT (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_s)
  );

  assign idx_s            = lfsr_s[IDX_W-1:0];
  assign unused_lfsr_hi_s = ^lfsr_s[15:IDX_W];

  // Only a fresh rising edge seen while idle starts a generation; edges in
  // other states are dropped, never queued.
  assign accept_s    = bus.start & ~start_q_r & (state_r == IDLE);
  assign slot_free_s = ~work_r[idx_s];
  assign tiles_inc_s = tiles_r + 4'd1;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic. PLACE ends on the cycle whose placement brings
  // the count up to the target; a collision simply stays in PLACE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = CLEAR;
        end else begin
          state_next_s = IDLE;
        end
      end
      CLEAR: begin
        state_next_s = PLACE;
      end
      PLACE: begin
        if (slot_free_s && (tiles_inc_s == target_r)) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = PLACE;
        end
      end
      FINISH: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM output decode. busy/done are registered from the next state so that
  // they line up with the state the FSM is actually in.
  always_comb begin
    clear_s      = 1'b0;
    place_s      = 1'b0;
    load_board_s = 1'b0;
    case (state_r)
      IDLE: begin
        clear_s = 1'b0;
      end
      CLEAR: begin
        clear_s = 1'b1;
      end
      PLACE: begin
        if (slot_free_s) begin
          place_s = 1'b1;
        end else begin
          place_s = 1'b0;
        end
      end
      FINISH: begin
        load_board_s = 1'b1;
      end
      default: begin
        clear_s = 1'b0;
      end
    endcase
    busy_next_s = (state_next_s == CLEAR) || (state_next_s == PLACE);
    done_next_s = (state_next_s == FINISH);
  end

  // Datapath registers: start edge detector, target latch, working board,
  // placement counter, visible board and the registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q_r <= 1'b0;
      target_r  <= 4'd0;
      work_r    <= {BOARD_W{1'b0}};
      tiles_r   <= 4'd0;
      board_r   <= {BOARD_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      start_q_r <= bus.start;
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
      if (accept_s) begin
        target_r <= clamp_target(bus.num_tiles);
      end
      if (clear_s) begin
        work_r  <= {BOARD_W{1'b0}};
        tiles_r <= 4'd0;
      end else if (place_s) begin
        work_r[idx_s] <= 1'b1;
        tiles_r       <= tiles_inc_s;
      end
      // The visible board only ever takes a complete working board.
      if (load_board_s) begin
        board_r <= work_r;
      end
    end
  end

  assign bus.board        = board_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.tiles_placed = tiles_r;

endmodule

// File: tb/tb_board_generator.sv
// -----------------------------------------------------------------------------
// tb_board_generator
// Self-checking bench for board_generator. A timeline model predicts, for
// each accepted start, the whole generation (placement sequence, latency,
// final board) from the LFSR sequence and the placement rules; a compare
// process checks busy/done/tiles_placed/board against it every cycle.
// -----------------------------------------------------------------------------
module tb_board_generator;
  import memory_matrix_pkg::*;

  logic clk;
  logic reset;

  board_generator_if bus();

  board_generator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;
  int done_seen    = 0;

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr      = 16'h0000;
  bit          m_start_q   = 1'b0;
  bit          m_active    = 1'b0;
  int          m_j         = 0;
  int          m_len       = 0;
  int          m_target    = 0;
  int          m_tp_cur    = 0;
  logic [7:0]  m_board     = 8'h00;
  logic [7:0]  m_new_board = 8'h00;
  int          m_seq[$];

  bit          e_busy  = 1'b0;
  bit          e_done  = 1'b0;
  logic [7:0]  e_board = 8'h00;
  int          e_tp    = 0;

  // x^16+x^14+x^13+x^11+1, right-shifting form (the classic 0xACE1 example).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  function automatic int spec_target(input int n);
    if (n == 0) return 1;
    if (n > 7) return 7;
    return n;
  endfunction

  // Plan a generation: placement starts with LFSR value `first`; one
  // PLACE cycle per LFSR value until `target` distinct tiles are lit.
  function automatic void plan(input logic [15:0] first, input int target);
    logic [15:0] v;
    logic [7:0]  work;
    int          n;
    v = first; work = 8'h00; n = 0;
    m_seq.delete();
    while (n < target && m_seq.size() < 5000) begin
      if (work[v[2:0]] == 1'b0) begin
        work[v[2:0]] = 1'b1;
        n++;
      end
      m_seq.push_back(n);
      v = lfsr_step(v);
    end
    m_len       = m_seq.size();
    m_new_board = work;
    m_target    = target;
  endfunction

  // Model advances at every active edge. Cycle j after an accepted edge:
  // j=1 clear, j=2..len+1 placement, j=len+2 done, j=len+3 board visible.
  initial begin
    logic [15:0] pre;
    bit          acc;
    forever begin
      @(posedge clk);
      cycle++;
      if (!reset) begin
        m_lfsr = SEED; m_start_q = 1'b0; m_active = 1'b0;
        m_board = 8'h00; m_tp_cur = 0; m_j = 0;
      end else begin
        acc = bus.start && !m_start_q && !m_active;
        pre = m_lfsr;
        m_lfsr = lfsr_step(m_lfsr);
        m_start_q = bus.start;
        if (m_active) begin
          m_j++;
          if (m_j == m_len + 3) begin
            m_active = 1'b0;
            m_board  = m_new_board;
            m_tp_cur = m_target;
          end
        end
        if (acc) begin
          plan(lfsr_step(lfsr_step(pre)), spec_target(int'(bus.num_tiles)));
          m_active = 1'b1;
          m_j = 1;
        end
      end
      e_board = m_board;
      if (!m_active) begin
        e_busy = 1'b0; e_done = 1'b0; e_tp = m_tp_cur;
      end else if (m_j == 1) begin
        e_busy = 1'b1; e_done = 1'b0; e_tp = m_tp_cur;
      end else if (m_j == 2) begin
        e_busy = 1'b1; e_done = 1'b0; e_tp = 0;
      end else if (m_j <= m_len + 1) begin
        e_busy = 1'b1; e_done = 1'b0; e_tp = m_seq[m_j - 3];
      end else begin
        e_busy = 1'b0; e_done = 1'b1; e_tp = m_target;
      end
    end
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("done", 32'(bus.done), 32'(e_done));
      check("tiles_placed", 32'(bus.tiles_placed), 32'(e_tp));
      check("board", 32'(bus.board), 32'(e_board));
      if (bus.done === 1'b1) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gen(input int d0, input int max, input string name);
    int n;
    n = 0;
    while (done_seen == d0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done_seen != d0), 32'd1);
  endtask

  task automatic pulse(input int nt, input int len);
    bus.num_tiles = 4'(nt);
    bus.start = 1'b1;
    tick(len);
    bus.start = 1'b0;
  endtask

  initial begin
    int d0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.num_tiles = 4'd0;
    tick(3);
    reset = 1'b1;

    // Idle after reset; LFSR sequence pinned by hand-computed values.
    tick(1);
    check("model_lfsr_step1", 32'(m_lfsr), 32'h5670);
    tick(1);
    check("model_lfsr_step2", 32'(m_lfsr), 32'hAB38);
    check("reset_board", 32'(bus.board), 32'd0);

    // Determinism run: start rises so the 10th edge after release accepts.
    tick(7);
    d0 = done_seen;
    pulse(5, 1);
    wait_gen(d0, 60, "det_done_timeout");
    tick(2);
    check("det_popcount", 32'($countones(bus.board)), 32'd5);
    check("det_tiles", 32'(bus.tiles_placed), 32'd5);
    check("det_done_count", 32'(done_seen - d0), 32'd1);

    // Three tiles, busy the cycle after the edge, then a long idle hold.
    d0 = done_seen;
    pulse(3, 1);
    check("busy_next_cycle", 32'(bus.busy), 32'd1);
    wait_gen(d0, 60, "n3_done_timeout");
    tick(2);
    check("n3_popcount", 32'($countones(bus.board)), 32'd3);
    check("n3_tiles", 32'(bus.tiles_placed), 32'd3);
    tick(100);
    check("n3_done_count", 32'(done_seen - d0), 32'd1);

    // Clamp boundaries.
    d0 = done_seen;
    pulse(0, 1);
    wait_gen(d0, 60, "n0_done_timeout");
    tick(3);
    check("n0_popcount", 32'($countones(bus.board)), 32'd1);
    check("n0_done_count", 32'(done_seen - d0), 32'd1);
    d0 = done_seen;
    pulse(15, 1);
    wait_gen(d0, 200, "n15_done_timeout");
    tick(3);
    check("n15_popcount", 32'($countones(bus.board)), 32'd7);
    check("n15_done_count", 32'(done_seen - d0), 32'd1);

    // Start held high: one generation only, then a new edge starts another.
    d0 = done_seen;
    pulse(2, 1000);
    check("held_done_count", 32'(done_seen - d0), 32'd1);
    tick(2);
    pulse(4, 1);
    wait_gen(d0 + 1, 60, "rearm_done_timeout");
    tick(2);
    check("rearm_popcount", 32'($countones(bus.board)), 32'd4);
    check("rearm_done_count", 32'(done_seen - d0), 32'd2);

    // Second edge while busy is ignored.
    d0 = done_seen;
    pulse(6, 1);
    tick(1);
    pulse(6, 1);
    wait_gen(d0, 100, "busy_edge_timeout");
    tick(20);
    check("busy_edge_done_count", 32'(done_seen - d0), 32'd1);

    // Reset in the middle of placement.
    pulse(7, 1);
    tick(2);
    check("mid_place_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("abort_board", 32'(bus.board), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    d0 = done_seen;
    tick(30);
    check("abort_no_done", 32'(done_seen - d0), 32'd0);

    // Randomised generations with glitches and occasional aborts.
    for (int it = 0; it < 40; it++) begin
      int nt;
      int plen;
      bit do_rst;
      nt = int'($urandom_range(0, 15));
      plen = int'($urandom_range(1, 3));
      do_rst = ($urandom_range(0, 7) == 0);
      d0 = done_seen;
      pulse(nt, plen);
      if (do_rst) begin
        tick(int'($urandom_range(0, 2)));
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        check("rand_abort_board", 32'(bus.board), 32'd0);
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          tick(1);
          pulse(nt, 1);
        end
        wait_gen(d0, 200, "rand_done_timeout");
        tick(3);
        check("rand_popcount", 32'($countones(bus.board)), 32'(spec_target(nt)));
      end
      tick(int'($urandom_range(0, 5)));
    end

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
